// File: rtl/duck_pkg.sv
// Shared types and screen constants for the duck sprite engine and other
// per-frame screen objects.
package duck_pkg;

  typedef enum logic [1:0] {
    FLY  = 2'd0,
    HIT  = 2'd1,
    FALL = 2'd2,
    GONE = 2'd3
  } duck_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // One axis of motion after a bounce step: clamped position and velocity.
  typedef struct packed {
    logic [9:0]         pos;
    logic signed [10:0] vel;
  } axis_step_t;

endpackage

// File: rtl/duck_sprite_engine_frame_tick_sync.sv
// Brings a slow asynchronous frame strobe (VGA vsync) into the clk domain
// and emits a one-cycle tick per rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic tick
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // p0/p1 resolve metastability; p2 holds the previous level for the edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
      tick    <= 1'b0;
    end else begin
      sync_p0 <= level;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      tick    <= sync_p1 & ~prev_p2;
    end
  end

endmodule

// File: rtl/duck_sprite_engine.sv
// Duck sprite: position, bouncing flight, flap animation, shot detection and
// the hit/fall/respawn life cycle, plus combinational sprite-sheet addressing.
module duck_sprite_engine
  import duck_pkg::*;
#(
  parameter int DUCK_W         = 40,
  parameter int DUCK_H         = 40,
  parameter int X_MAX          = SCREEN_W - 40,
  parameter int Y_MAX          = 300,
  parameter int START_X        = 300,
  parameter int START_Y        = 300,
  parameter int VX0            = 2,
  parameter int VY0            = 2,
  parameter int FLAP_FRAMES    = 8,
  parameter int HIT_FRAMES     = 30,
  parameter int FALL_SPEED     = 4,
  parameter int RESPAWN_FRAMES = 60
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       shot_valid,
  input  logic [9:0] shot_x,
  input  logic [9:0] shot_y,
  output logic       is_duck,
  output logic [9:0] Duck_Draw_X,
  output logic [9:0] Duck_Draw_Y,
  output logic [1:0] duck_state,
  output logic       hit_pulse
);

  localparam logic signed [10:0] X_LIM = 11'(X_MAX);
  localparam logic signed [10:0] Y_LIM = 11'(Y_MAX);
  localparam int CNT_MAX = (HIT_FRAMES > RESPAWN_FRAMES) ? HIT_FRAMES : RESPAWN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLAP_W  = $clog2(FLAP_FRAMES + 1);

  // Advance one axis by its velocity; bouncing off either wall clamps the
  // position to the wall and reverses the velocity. 11-bit signed math lets
  // an underflow below zero show up as a negative value before clamping.
  function automatic axis_step_t bounce(input logic [9:0] pos,
                                        input logic signed [10:0] vel,
                                        input logic signed [10:0] lim);
    axis_step_t r;
    logic signed [10:0] n;
    n = $signed({1'b0, pos}) + vel;
    if (n < 0) begin
      r.pos = '0;
      r.vel = -vel;
    end else if (n > lim) begin
      r.pos = 10'(lim);
      r.vel = -vel;
    end else begin
      r.pos = n[9:0];
      r.vel = vel;
    end
    return r;
  endfunction

  duck_state_t        state, nxt_state;
  logic [9:0]         pos_x, pos_y, nxt_x, nxt_y;
  logic signed [10:0] vx, vy, nxt_vx, nxt_vy;
  logic               flap, nxt_flap;
  logic [FLAP_W-1:0]  flap_cnt, nxt_flap_cnt;
  logic [CNT_W-1:0]   frame_cnt, nxt_cnt;
  logic               nxt_hit;
  logic               frame_tick;
  logic               shot_in_box, shot_hit;
  axis_step_t         step_x, step_y;
  logic [10:0]        fall_y;
  logic [9:0]         off_x, off_y;
  logic               in_x, in_y;

  frame_tick_sync u_tick (
    .clk  (Clk),
    .rst  (Reset),
    .level(frame_clk),
    .tick (frame_tick)
  );

  assign shot_in_box = (shot_x >= pos_x) && ((shot_x - pos_x) < 10'(DUCK_W)) &&
                       (shot_y >= pos_y) && ((shot_y - pos_y) < 10'(DUCK_H));
  assign shot_hit    = shot_valid && (state == FLY) && shot_in_box;

  assign step_x = bounce(pos_x, vx, X_LIM);
  assign step_y = bounce(pos_y, vy, Y_LIM);
  assign fall_y = {1'b0, pos_y} + 11'(FALL_SPEED);

  always_comb begin
    nxt_state    = state;
    nxt_x        = pos_x;
    nxt_y        = pos_y;
    nxt_vx       = vx;
    nxt_vy       = vy;
    nxt_flap     = flap;
    nxt_flap_cnt = flap_cnt;
    nxt_cnt      = frame_cnt;
    nxt_hit      = 1'b0;
    // A hit takes priority over a coincident frame tick: the duck freezes where it was shot.
    if (shot_hit) begin
      nxt_state = HIT;
      nxt_hit   = 1'b1;
      nxt_cnt   = '0;
      nxt_flap  = 1'b1;
    end else if (frame_tick) begin
      case (state)
        FLY: begin
          nxt_x  = step_x.pos;
          nxt_vx = step_x.vel;
          nxt_y  = step_y.pos;
          nxt_vy = step_y.vel;
          if (flap_cnt == FLAP_W'(FLAP_FRAMES - 1)) begin
            nxt_flap_cnt = '0;
            nxt_flap     = ~flap;
          end else begin
            nxt_flap_cnt = flap_cnt + 1'b1;
          end
        end
        HIT: begin
          nxt_flap = 1'b1;
          if (frame_cnt == CNT_W'(HIT_FRAMES - 1)) begin
            nxt_state = FALL;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = frame_cnt + 1'b1;
          end
        end
        FALL: begin
          if (fall_y >= 11'(Y_MAX)) begin
            nxt_y     = 10'(Y_MAX);
            nxt_state = GONE;
            nxt_cnt   = '0;
          end else begin
            nxt_y = fall_y[9:0];
          end
        end
        GONE: begin
          if (frame_cnt == CNT_W'(RESPAWN_FRAMES - 1)) begin
            nxt_state    = FLY;
            nxt_cnt      = '0;
            nxt_x        = 10'(START_X);
            nxt_y        = 10'(START_Y);
            nxt_vx       = -vx;
            nxt_vy       = -11'sd1 * 11'(VY0);
            nxt_flap     = 1'b0;
            nxt_flap_cnt = '0;
          end else begin
            nxt_cnt = frame_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= FLY;
      pos_x     <= 10'(START_X);
      pos_y     <= 10'(START_Y);
      vx        <= 11'(VX0);
      vy        <= -11'sd1 * 11'(VY0);
      flap      <= 1'b0;
      flap_cnt  <= '0;
      frame_cnt <= '0;
      hit_pulse <= 1'b0;
    end else begin
      state     <= nxt_state;
      pos_x     <= nxt_x;
      pos_y     <= nxt_y;
      vx        <= nxt_vx;
      vy        <= nxt_vy;
      flap      <= nxt_flap;
      flap_cnt  <= nxt_flap_cnt;
      frame_cnt <= nxt_cnt;
      hit_pulse <= nxt_hit;
    end
  end

  // Pixel side stays combinational so it lines up with the colour mapper's ROM lookup.
  assign off_x = DrawX - pos_x;
  assign off_y = DrawY - pos_y;
  assign in_x  = (DrawX >= pos_x) && (off_x < 10'(DUCK_W));
  assign in_y  = (DrawY >= pos_y) && (off_y < 10'(DUCK_H));

  assign is_duck     = (state != GONE) && in_x && in_y;
  assign Duck_Draw_X = is_duck ? (off_x + (flap ? 10'(DUCK_W) : 10'd0)) : 10'd0;
  assign Duck_Draw_Y = is_duck ? off_y : 10'd0;
  assign duck_state  = state;

endmodule

// File: doc/duck_sprite_engine.md
Name: duck_sprite_engine

Overview:
- Produces the duck sprite signals consumed by the colour mapper: `is_duck`, `Duck_Draw_X` and `Duck_Draw_Y` for the current `DrawX`/`DrawY`.
- Owns duck position, per-frame motion with edge bounce, wing-flap animation, shot hit detection, and the hit/fall/respawn life cycle.
- Position and state are registered.
- The pixel-side outputs are combinational from `DrawX`/`DrawY` and the registered position. This keeps them aligned with the colour mapper's combinational ROM lookup.

Parameters:
- DUCK_W, 40, sprite width in pixels (two flap frames side by side make an 80-pixel-wide ROM row).
- DUCK_H, 40, sprite height in pixels.
- X_MAX, 600, largest legal left-edge X (640 - DUCK_W).
- Y_MAX, 300, largest legal top-edge Y (duck must stay above the grass line).
- START_X, 300, respawn X.
- START_Y, 300, respawn Y.
- VX0, 2, initial horizontal speed magnitude (pixels/frame).
- VY0, 2, initial vertical speed magnitude (pixels/frame, upward at spawn).
- FLAP_FRAMES, 8, frames per flap-image toggle.
- HIT_FRAMES, 30, freeze time after a hit.
- FALL_SPEED, 4, fall speed (pixels/frame).
- RESPAWN_FRAMES, 60, invisible wait before respawn.

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset  in  1  asynchronous, active-high
- frame_clk  in  1  VGA vertical sync, asynchronous to nothing but slow; rising edge = one frame tick
- DrawX  in  10  current pixel X
- DrawY  in  10  current pixel Y
- shot_valid  in  1  one-cycle pulse, trigger pulled
- shot_x  in  10  aim X, sampled when shot_valid=1
- shot_y  in  10  aim Y, sampled when shot_valid=1
- is_duck  out  1  current pixel lies inside the visible sprite box
- Duck_Draw_X  out  10  ROM column (0..79) inside the sprite sheet
- Duck_Draw_Y  out  10  ROM row (0..DUCK_H-1)
- duck_state  out  2  0=FLY, 1=HIT, 2=FALL, 3=GONE
- hit_pulse  out  1  one-cycle pulse on an accepted hit (to the score logic)

Behaviour:
- Reset (async):
  - pos_x=START_X, pos_y=START_Y, vx=+VX0, vy=-VY0.
  - state=FLY, flap=0, frame counters=0.
  - hit_pulse=0, duck_state=0.
- Frame tick:
  - frame_clk goes through a 2-flop synchroniser plus an edge detector.
  - frame_tick is a one-Clk pulse, 3 Clk after the rising edge.
  - All motion and counter updates happen only on frame_tick.
- FLY:
  - nx = pos_x + vx; if nx < 0 → pos_x=0, vx=-vx; if nx > X_MAX → pos_x=X_MAX, vx=-vx; else pos_x=nx.
  - Y is handled the same way against the range 0..Y_MAX.
  - Arithmetic is 11-bit signed so underflow is detected before clamping.
  - Flap counter counts to FLAP_FRAMES-1, then wraps and toggles flap.
- Hit detection (FLY only, any cycle with shot_valid=1):
  - A hit is pos_x <= shot_x < pos_x+DUCK_W and pos_y <= shot_y < pos_y+DUCK_H, using the current registered position.
  - On a hit: state→HIT next Clk, hit_pulse=1 for exactly one Clk, frame counter cleared.
  - A shot and a frame_tick in the same cycle: the hit wins and no motion is applied that cycle.
  - Shots in HIT, FALL or GONE are ignored, with no pulse.
- HIT:
  - Position is frozen and flap is forced to 1.
  - After HIT_FRAMES ticks → FALL.
- FALL:
  - pos_y += FALL_SPEED per tick.
  - When pos_y + FALL_SPEED >= Y_MAX: pos_y=Y_MAX, state→GONE, counter cleared.
- GONE:
  - is_duck is forced 0.
  - After RESPAWN_FRAMES ticks: position reloads to START, vy=-VY0, vx is negated relative to the last life, flap=0, state→FLY.
- Pixel outputs (combinational):
  - is_duck = (state≠GONE) and DrawX in [pos_x, pos_x+DUCK_W) and DrawY in [pos_y, pos_y+DUCK_H).
  - Duck_Draw_X = DrawX - pos_x + (flap ? DUCK_W : 0).
  - Duck_Draw_Y = DrawY - pos_y.
  - When is_duck=0, Duck_Draw_X/Y are 0.
- Reset mid-operation: takes effect immediately regardless of state, and any pending hit_pulse is cleared.

Decomposition:
- Package duck_pkg holds:
  - typedef enum logic [1:0] duck_state_t {FLY, HIT, FALL, GONE};
  - screen constants SCREEN_W=640, SCREEN_H=480.
- One sub-module, frame_tick_sync: the 2-flop synchroniser plus rising-edge detector that produces frame_tick. It is reusable by other per-frame objects.

Test Plan:
- Reset, then drive DrawX=300, DrawY=300 → is_duck=1, Duck_Draw_X=0, Duck_Draw_Y=0, duck_state=0. After one frame tick: pos=(302,298).
- Run frames until pos_x reaches 600 → next tick pos_x=600 with vx=-2. Following tick pos_x=598, with no value ever above 600.
- shot_valid with shot_x=pos_x+39, shot_y=pos_y → hit_pulse high exactly 1 Clk, duck_state=1. Same with shot_x=pos_x+40 → no hit.
- shot_valid coincident with frame_tick on an in-box aim → HIT entered, position unchanged from the pre-tick value.
- After a hit: 30 ticks → FALL; pos_y rises by 4 per tick to 300 → GONE with is_duck=0; 60 ticks → FLY at (300,300) with vx=-2. A shot during GONE gives no hit_pulse.
- Assert Reset during FALL → all outputs return to reset values without a clock edge. Deassert → FLY resumes from START.
